// File: rtl/cdi_mem_pkg.sv
// Shared types and constants for the CD-i external memory arbiter.
package cdi_mem_pkg;

    localparam int ADDR_W = 24;

    // Read data returned to the owner when a read is abandoned by the watchdog
    localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

    typedef enum logic [1:0] {
        REQ_VID = 2'd0,
        REQ_CPU = 2'd1,
        REQ_DL  = 2'd2
    } req_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wdata;
        logic [1:0]        be;
    } mem_cmd_t;

endpackage

// File: rtl/cdi_arb_watchdog.sv
// WAIT-state cycle counter with a sticky error flag. Only instantiated when
// the arbiter is built with CDI_ARB_TIMEOUT_EN.
module cdi_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,   // arbiter is entering WAIT this cycle
    input  logic wait_i,    // arbiter is in WAIT
    input  logic rvalid_i,  // a real completion beats the timeout
    output logic expire_o,
    output logic err_o
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // The counter equals the number of WAIT cycles already spent
    assign expire_o = wait_i && !rvalid_i && (cnt_q == CNT_W'(TIMEOUT));
    assign err_o    = err_q;

    // Next-state: clear on WAIT entry, count while waiting, latch any expiry
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | expire_o;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wait_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and sticky flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/cdi_mem_arbiter.sv
// Three-way arbiter for the single 16-bit external memory port.
// Video has fixed priority; CPU and download alternate round-robin.
// Optional WAIT timeout + sticky err: define CDI_ARB_TIMEOUT_EN.
module cdi_mem_arbiter
    import cdi_mem_pkg::req_id_t, cdi_mem_pkg::REQ_VID, cdi_mem_pkg::REQ_CPU,
           cdi_mem_pkg::REQ_DL, cdi_mem_pkg::arb_state_t, cdi_mem_pkg::IDLE,
           cdi_mem_pkg::ISSUE, cdi_mem_pkg::WAIT, cdi_mem_pkg::DONE,
           cdi_mem_pkg::TIMEOUT_RDATA;
#(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic              cpu_req,
    input  logic              dl_req,
    input  logic              vid_we,
    input  logic              cpu_we,
    input  logic              dl_we,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [15:0]       vid_wdata,
    input  logic [15:0]       cpu_wdata,
    input  logic [15:0]       dl_wdata,
    input  logic [1:0]        vid_be,
    input  logic [1:0]        cpu_be,
    input  logic [1:0]        dl_be,
    output logic              vid_ack,
    output logic              cpu_ack,
    output logic              dl_ack,
    output logic [15:0]       vid_rdata,
    output logic [15:0]       cpu_rdata,
    output logic [15:0]       dl_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic              err
);

    arb_state_t        state_q, state_d;
    req_id_t           owner_q, grant_d;
    logic              take_d;          // latch a new command this cycle
    logic              rr_cpu_last_q;   // 1: CPU was the last of CPU/DL served
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [1:0]        be_q;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_wdata;
    logic [1:0]        sel_be;
    logic              timeout_hit;
    logic              rdata_wr;
    logic [15:0]       rdata_fill;
    logic [2:0]        ack_vec;
    logic [47:0]       rdata_all;

    // Next-state and grant selection
    always_comb begin
        state_d = state_q;
        grant_d = owner_q;
        take_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (vid_req) begin
                    grant_d = REQ_VID;
                    take_d  = 1'b1;
                end else if (cpu_req && dl_req) begin
                    grant_d = rr_cpu_last_q ? REQ_DL : REQ_CPU;
                    take_d  = 1'b1;
                end else if (cpu_req) begin
                    grant_d = REQ_CPU;
                    take_d  = 1'b1;
                end else if (dl_req) begin
                    grant_d = REQ_DL;
                    take_d  = 1'b1;
                end
                if (take_d) state_d = ISSUE;
            end
            ISSUE:   if (mem_ready) state_d = WAIT;
            WAIT:    if (mem_rvalid || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Field mux for the requester being granted
    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        sel_be    = cpu_be;
        case (grant_d)
            REQ_VID: begin
                sel_we = vid_we; sel_addr = vid_addr; sel_wdata = vid_wdata; sel_be = vid_be;
            end
            REQ_DL: begin
                sel_we = dl_we; sel_addr = dl_addr; sel_wdata = dl_wdata; sel_be = dl_be;
            end
            default: ;
        endcase
    end

    // State, owner, round-robin pointer and latched command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= REQ_VID;
            rr_cpu_last_q <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
        end else begin
            state_q <= state_d;
            if (take_d) begin
                owner_q <= grant_d;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                be_q    <= sel_be;
                if (grant_d == REQ_CPU) rr_cpu_last_q <= 1'b1;
                else if (grant_d == REQ_DL) rr_cpu_last_q <= 1'b0;
            end
        end
    end

    assign mem_valid = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

    // Writes complete without touching the owner's read data
    assign rdata_wr   = (state_q == WAIT) && (mem_rvalid || timeout_hit) && !we_q;
    assign rdata_fill = mem_rvalid ? mem_rdata : TIMEOUT_RDATA;

    for (genvar gi = 0; gi < 3; gi++) begin : g_req
        logic [15:0] rdata_q;

        // Per-requester read data holding register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdata_q <= '0;
            end else if (rdata_wr && (owner_q == req_id_t'(gi))) begin
                rdata_q <= rdata_fill;
            end
        end

        assign rdata_all[gi*16 +: 16] = rdata_q;
        assign ack_vec[gi]            = (state_q == DONE) && (owner_q == req_id_t'(gi));
    end

    assign vid_rdata = rdata_all[15:0];
    assign cpu_rdata = rdata_all[31:16];
    assign dl_rdata  = rdata_all[47:32];
    assign vid_ack   = ack_vec[0];
    assign cpu_ack   = ack_vec[1];
    assign dl_ack    = ack_vec[2];

`ifdef CDI_ARB_TIMEOUT_EN
    cdi_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  ((state_q == ISSUE) && mem_ready),
        .wait_i   (state_q == WAIT),
        .rvalid_i (mem_rvalid),
        .expire_o (timeout_hit),
        .err_o    (err)
    );
`else
    // Without the watchdog WAIT blocks until the controller responds
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_cdi_mem_arbiter.sv
// Directed bench for cdi_mem_arbiter; covers the watchdog when built with
// CDI_ARB_TIMEOUT_EN (TIMEOUT = 16), blocking WAIT otherwise.
module tb_cdi_mem_arbiter;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req, cpu_req, dl_req;
    logic          vid_we, cpu_we, dl_we;
    logic [AW-1:0] vid_addr, cpu_addr, dl_addr;
    logic [15:0]   vid_wdata, cpu_wdata, dl_wdata;
    logic [1:0]    vid_be, cpu_be, dl_be;
    logic          vid_ack, cpu_ack, dl_ack;
    logic [15:0]   vid_rdata, cpu_rdata, dl_rdata;
    logic          mem_valid, mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [1:0]    mem_be;
    logic          mem_ready, mem_rvalid;
    logic [15:0]   mem_rdata;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cdi_mem_arbiter #(.ADDR_W(AW), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .cpu_req(cpu_req), .dl_req(dl_req),
        .vid_we(vid_we), .cpu_we(cpu_we), .dl_we(dl_we),
        .vid_addr(vid_addr), .cpu_addr(cpu_addr), .dl_addr(dl_addr),
        .vid_wdata(vid_wdata), .cpu_wdata(cpu_wdata), .dl_wdata(dl_wdata),
        .vid_be(vid_be), .cpu_be(cpu_be), .dl_be(dl_be),
        .vid_ack(vid_ack), .cpu_ack(cpu_ack), .dl_ack(dl_ack),
        .vid_rdata(vid_rdata), .cpu_rdata(cpu_rdata), .dl_rdata(dl_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait transaction for the expected owner (0 vid, 1 cpu, 2 dl);
    // the memory returns d one cycle after accepting the command.
    task automatic do_xact(input int who, input logic [15:0] d);
        int          n;
        logic [23:0] exp_addr;
        logic [2:0]  exp_ack;
        logic [15:0] got;
        n        = 0;
        exp_addr = (who == 0) ? 24'h10 : (who == 1) ? 24'h20 : 24'h30;
        exp_ack  = (who == 0) ? 3'b100 : (who == 1) ? 3'b010 : 3'b001;
        while (!mem_valid && n < 20) begin
            tick();
            n++;
        end
        chk("grant_valid", mem_valid, 1);
        chk("grant_addr", mem_addr, exp_addr);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
        got = (who == 0) ? vid_rdata : (who == 1) ? cpu_rdata : dl_rdata;
        chk("grant_ack", {vid_ack, cpu_ack, dl_ack}, exp_ack);
        chk("grant_rdata", got, d);
        $display("xact owner=%0d addr=%h rdata=%h", who, mem_addr, got);
        if (who == 0) vid_req = 1'b0;
        else if (who == 1) cpu_req = 1'b0;
        else dl_req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        {vid_req, cpu_req, dl_req, vid_we, cpu_we, dl_we} = '0;
        vid_addr = 24'h10; cpu_addr = 24'h20; dl_addr = 24'h30;
        vid_wdata = '0; cpu_wdata = '0; dl_wdata = '0;
        vid_be = 2'b11; cpu_be = 2'b11; dl_be = 2'b11;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state
        #3;
        chk("rst_valid_we", {mem_valid, mem_we}, 0);
        chk("rst_acks", {vid_ack, cpu_ack, dl_ack}, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd", {mem_addr, mem_wdata, mem_be}, 0);
        chk("rst_rdata", {vid_rdata, cpu_rdata, dl_rdata}, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Simultaneous requests: vid, then dl (first tie), then cpu
        vid_req = 1'b1; cpu_req = 1'b1; dl_req = 1'b1;
        do_xact(0, 16'hA001);
        do_xact(2, 16'hD001);
        do_xact(1, 16'hC001);
        cpu_req = 1'b1; dl_req = 1'b1;
        do_xact(2, 16'hD002);
        do_xact(1, 16'hC002);

        // Download write with the controller stalling for 5 cycles
        dl_req = 1'b1; dl_we = 1'b1; dl_addr = 24'h40; dl_wdata = 16'h1234; dl_be = 2'b10;
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("wr_hold", {mem_valid, mem_we, mem_be, mem_wdata, mem_addr}, {1'b1, 1'b1, 2'b10, 16'h1234, 24'h40});
            if (i == 1) begin
                dl_wdata = 16'hFFFF;
                dl_be    = 2'b11;
            end
            tick();
        end
        mem_ready = 1'b1;
        tick();
        chk("wr_valid_drop", mem_valid, 0);
        mem_rvalid = 1'b1; mem_rdata = 16'hAAAA;
        tick();
        mem_rvalid = 1'b0;
        chk("wr_ack", {vid_ack, cpu_ack, dl_ack}, 3'b001);
        chk("wr_rdata_kept", dl_rdata, 16'hD002);
        $display("xact owner=2 write addr=%h data=1234 be=10", mem_addr);
        dl_req = 1'b0; dl_we = 1'b0; dl_addr = 24'h30; dl_be = 2'b11;
        tick();

        // Spurious completion while idle
        mem_rvalid = 1'b1; mem_rdata = 16'h5555;
        tick();
        mem_rvalid = 1'b0;
        chk("spur_acks", {vid_ack, cpu_ack, dl_ack}, 0);
        chk("spur_rdata", {vid_rdata, cpu_rdata, dl_rdata}, {16'hA001, 16'hC002, 16'hD002});
        tick();
        chk("spur_acks2", {vid_ack, cpu_ack, dl_ack, mem_valid}, 0);

        // CPU read: ready at once, rvalid three cycles after acceptance
        cpu_addr = 24'h000100; cpu_req = 1'b1;
        tick();
        chk("rd_cmd", {mem_valid, mem_we, mem_addr}, {1'b1, 1'b0, 24'h000100});
        tick();
        chk("rd_wait_noack", {vid_ack, cpu_ack, dl_ack, mem_valid}, 0);
        tick();
        tick();
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        chk("rd_noack_early", {vid_ack, cpu_ack, dl_ack}, 0);
        tick();
        mem_rvalid = 1'b0;
        chk("rd_ack", {vid_ack, cpu_ack, dl_ack}, 3'b010);
        chk("rd_rdata", cpu_rdata, 16'hBEEF);
        $display("xact owner=1 addr=000100 rdata=%h", cpu_rdata);
        cpu_req = 1'b0;
        tick();
        chk("rd_ack_once", {vid_ack, cpu_ack, dl_ack}, 0);

        // Reset during WAIT abandons the transaction
        cpu_addr = 24'h200; cpu_req = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("arst_ctl", {mem_valid, mem_we, vid_ack, cpu_ack, dl_ack, err}, 0);
        chk("arst_cmd", {mem_addr, mem_wdata, mem_be}, 0);
        chk("arst_rdata", {vid_rdata, cpu_rdata, dl_rdata}, 0);
        cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_ack", {vid_ack, cpu_ack, dl_ack, mem_valid}, 0);
        end
        $display("xact owner=1 addr=000200 abandoned by reset");

`ifdef CDI_ARB_TIMEOUT_EN
        // Read with no completion: watchdog answers 17 cycles after WAIT entry
        cpu_addr = 24'h300; cpu_req = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 16; i++) tick();
        chk("to_noack_16", {cpu_ack, err}, 0);
        tick();
        chk("to_ack_17", {vid_ack, cpu_ack, dl_ack}, 3'b010);
        chk("to_rdata", cpu_rdata, 16'hFFFF);
        chk("to_err", err, 1);
        $display("xact owner=1 addr=000300 timed out rdata=%h", cpu_rdata);
        cpu_req = 1'b0;
        tick();
        cpu_addr = 24'h20; cpu_req = 1'b1;
        do_xact(1, 16'h1357);
        chk("to_err_sticky", err, 1);
`else
        // Read with no completion blocks until the controller answers
        cpu_addr = 24'h300; cpu_req = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 30; i++) tick();
        chk("blk_noack", {vid_ack, cpu_ack, dl_ack}, 0);
        mem_rvalid = 1'b1; mem_rdata = 16'h2468;
        tick();
        mem_rvalid = 1'b0;
        chk("blk_ack", {vid_ack, cpu_ack, dl_ack}, 3'b010);
        chk("blk_rdata", cpu_rdata, 16'h2468);
        $display("xact owner=1 addr=000300 rdata=%h", cpu_rdata);
        cpu_req = 1'b0;
        tick();
        chk("blk_err_zero", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdi_mem_arbiter.md
# cdi_mem_arbiter

Shares the single 16-bit external memory port between three requesters: video fetch, CPU, and the HPS ROM/disc-image download path. It sits between `cditop`'s memory clients and the SDRAM controller. It serialises one transaction at a time and returns read data and completion acks to the owner. Video has fixed top priority; CPU and download alternate round-robin.

## Interface
Parameters:
- `ADDR_W`, 24: word address width.
- `TIMEOUT`, 255: WAIT-state cycle limit. Used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `vid_req`, `cpu_req`, `dl_req`  in  1 each  level request; held until the matching ack.
- `vid_we`, `cpu_we`, `dl_we`  in  1 each  1 = write.
- `vid_addr`, `cpu_addr`, `dl_addr`  in  ADDR_W each  word address.
- `vid_wdata`, `cpu_wdata`, `dl_wdata`  in  16 each  write data.
- `vid_be`, `cpu_be`, `dl_be`  in  2 each  byte enables; bit1 = upper byte.
- `vid_ack`, `cpu_ack`, `dl_ack`  out  1 each  one-cycle completion pulse.
- `vid_rdata`, `cpu_rdata`, `dl_rdata`  out  16 each  read data, valid from the ack cycle onward.
- `mem_valid`  out  1  command valid.
- `mem_we`  out  1  command is a write.
- `mem_addr`  out  ADDR_W  command address.
- `mem_wdata`  out  16  command write data.
- `mem_be`  out  2  command byte enables.
- `mem_ready`  in  1  controller accepts the command when `mem_valid & mem_ready`.
- `mem_rvalid`  in  1  completion for reads and writes; one pulse per accepted command.
- `mem_rdata`  in  16  read data, qualified by `mem_rvalid`.
- `err`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any request is high, pick the owner and latch its we/addr/wdata/be into the command register, then go to ISSUE.
  - Priority: `vid_req` wins outright.
  - Otherwise, if only one of CPU/download requests, it wins.
  - If both request, the one not served last wins.
- **Round-robin pointer**
  - Updates only on CPU or download grants. Video grants leave it unchanged.
  - Reset value: CPU is considered last served, so download wins the first tie.
- **ISSUE:** hold `mem_valid` = 1 with the latched command. On `mem_ready` go to WAIT and drop `mem_valid` next cycle.
- **WAIT**
  - On `mem_rvalid`: capture `mem_rdata` into the owner's rdata register (reads only; writes leave rdata unchanged), then go to DONE.
  - `mem_rvalid` in any other state is ignored.
- **DONE:** pulse the owner's ack for exactly one cycle, then go to IDLE.
- Requester contract:
  - Drop req no later than the cycle after it sees ack.
  - IDLE samples at the end of its first cycle, so a registered deassert is not re-granted.
  - Fields must be stable from req rise to ack.
- Input changes after the command is latched do not affect the transaction in flight.

## Timing
- Reset values:
  - State IDLE.
  - `mem_valid`, `mem_we`, all acks and `err`: 0.
  - All addr/data/be outputs and all rdata outputs: 0.
- Latency:
  - Request high in IDLE cycle 0 → `mem_valid` high in cycle 1.
  - Ready in cycle n → WAIT from n+1.
  - `mem_rvalid` in cycle m → ack in cycle m+1.
  - Minimum 4 cycles per transaction with zero-wait memory.
- Mid-operation reset abandons the transaction immediately. The memory controller shares `reset`, so no orphan response is expected.
- A request asserted during a busy transaction is evaluated at the next IDLE. Video therefore waits at most one in-flight transaction.

## Configuration
- `CDI_ARB_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter runs in WAIT.
  - After `TIMEOUT` cycles without `mem_rvalid`: owner rdata = 16'hFFFF (reads only), go to DONE with a normal ack, and set `err` (sticky until reset).
  - The counter clears on entering WAIT.
- Undefined: `err` is tied 0, no counter exists, and WAIT blocks indefinitely.

## Structure
- Package `cdi_mem_pkg` contains:
  - `req_id_t` enum: REQ_VID=0, REQ_CPU=1, REQ_DL=2.
  - `arb_state_t` enum.
  - `mem_cmd_t` struct {we, addr, wdata, be}, parameterised via `ADDR_W` package localparam default 24.
  - Constant `TIMEOUT_RDATA` = 16'hFFFF.
- Sub-module `cdi_arb_watchdog` (WAIT-cycle counter plus sticky err). Instantiated only under `CDI_ARB_TIMEOUT_EN`.

## Test plan
- CPU read addr 0x000100, memory ready immediately, rvalid 3 cycles later with 0xBEEF → `cpu_ack` one cycle, `cpu_rdata` = 0xBEEF, no other ack.
- vid, cpu and dl all request in the same cycle → grant order vid, dl, cpu. Re-request cpu and dl → dl, then cpu.
- Download write 0x1234 with be=2'b10 while `mem_ready` is low for 5 cycles → `mem_valid` held steadily with constant fields; `dl_rdata` unchanged after ack.
- Async reset asserted during WAIT → all outputs 0 in the same cycle. After release, no ack appears for the abandoned transaction.
- With `CDI_ARB_TIMEOUT_EN` and `TIMEOUT`=16, CPU read with no rvalid → `cpu_ack` 17 cycles after WAIT entry, rdata 0xFFFF, `err` = 1 and stays 1 through later good transactions.
- Spurious `mem_rvalid` in IDLE → no ack, no rdata change.
